pc_fetch_ctrl: RTL and testbench

//  Parametrised program-counter generator for the IF stage; successor to the fixed 32-bit PC register.

---
 rtl/pc_fetch_ctrl.sv | 119 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Program-counter generator for the instruction-fetch stage.
// Picks the next fetch address with priority flush > branch > sequential,
// holds the PC while imem or the IF stage is not ready, and parks a branch
// that arrives during a hold in a pending-redirect buffer until it can be applied.
module pc_fetch_ctrl #(
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_VEC  = '0,
    parameter int                 STEP       = 4,
    parameter int                 ALIGN_BITS = 2,
    parameter int                 STALL_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_pc,
    input  logic               br_valid,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               fetch_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               pc_valid,
    output logic               pc_misalign,
    output logic               redirect_pending
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] pc_nx;
    logic [ADDR_W-1:0] pend_target;
    logic [ADDR_W-1:0] pend_target_nx;
    logic              advance;

    // Only the IF bit of the stall vector matters to this stage.
    logic unused_stall;
    assign unused_stall = ^stall;

    // OR of the low ALIGN_BITS address bits; an empty loop (ALIGN_BITS=0) yields 0.
    function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
        logic m;
        m = 1'b0;
        for (int i = 0; i < ALIGN_BITS; i++) begin
            m = m | addr[i];
        end
        return m;
    endfunction

    assign advance = pc_valid & fetch_ready & ~stall[0];

    // State, PC and misalign flag; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_VEC;
            pc_misalign <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            pc_misalign <= misaligned(pc_nx);
        end
    end

    // Buffered branch target; its content only matters while in PEND, so no reset.
    always_ff @(posedge clk) begin
        pend_target <= pend_target_nx;
    end

    // Next state and next PC: flush beats branch beats sequential; branches during a hold get parked.
    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        pend_target_nx = pend_target;
        unique case (state)
            BOOT: begin
                // First fetch is RESET_VEC itself; redirects are ignored until running.
                state_nx = RUN;
            end
            RUN: begin
                if (flush) begin
                    pc_nx = flush_pc;
                end else if (advance) begin
                    pc_nx = br_valid ? br_target : pc + STEP_V;
                end else if (br_valid) begin
                    pend_target_nx = br_target;
                    state_nx       = PEND;
                end
            end
            PEND: begin
                if (flush) begin
                    pc_nx    = flush_pc;
                    state_nx = RUN;
                end else if (advance) begin
                    // A branch arriving on the releasing cycle is newer than the parked one.
                    pc_nx    = br_valid ? br_target : pend_target;
                    state_nx = RUN;
                end else if (br_valid) begin
                    pend_target_nx = br_target;
                end
            end
            default: begin
                state_nx = BOOT;
            end
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        pc_valid         = (state != BOOT);
        redirect_pending = (state == PEND);
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a 32-bit instance driven by directed
// scenarios and random traffic against a cycle model through a scoreboard,
// plus a 16-bit / STEP=2 instance exercised with directed checks.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        br_valid;
    logic [31:0] br_target;
    logic        fetch_ready;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_misalign;
    logic        redirect_pending;

    logic        b_rst;
    logic [5:0]  b_stall;
    logic        b_flush;
    logic [15:0] b_flush_pc;
    logic        b_br_valid;
    logic [15:0] b_br_target;
    logic        b_fetch_ready;
    logic [15:0] b_pc;
    logic        b_pc_valid;
    logic        b_pc_misalign;
    logic        b_redirect_pending;

    pc_fetch_ctrl #(
        .ADDR_W(32), .RESET_VEC(RV), .STEP(4), .ALIGN_BITS(2), .STALL_W(6)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .br_valid(br_valid), .br_target(br_target), .fetch_ready(fetch_ready),
        .pc(pc), .pc_valid(pc_valid), .pc_misalign(pc_misalign),
        .redirect_pending(redirect_pending)
    );

    pc_fetch_ctrl #(
        .ADDR_W(16), .RESET_VEC(16'h0010), .STEP(2), .ALIGN_BITS(1), .STALL_W(6)
    ) dut16 (
        .clk(clk), .rst(b_rst), .stall(b_stall), .flush(b_flush), .flush_pc(b_flush_pc),
        .br_valid(b_br_valid), .br_target(b_br_target), .fetch_ready(b_fetch_ready),
        .pc(b_pc), .pc_valid(b_pc_valid), .pc_misalign(b_pc_misalign),
        .redirect_pending(b_redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        vld;
        logic        mis;
        logic        pend;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Cycle model of the 32-bit instance: 0=BOOT 1=RUN 2=PEND
    int          m_st = 0;
    logic [31:0] m_pc = RV;
    logic [31:0] m_pend = '0;
    logic        m_mis = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Predict the post-edge outputs from the current inputs, then clock and compare.
    task automatic cycle();
        exp_t e;
        logic adv;
        adv = (m_st != 0) && fetch_ready && !stall[0];
        if (rst) begin
            m_st  = 0;
            m_pc  = RV;
            m_mis = 1'b0;
        end else begin
            if (m_st == 0) begin
                m_st = 1;
            end else if (flush) begin
                m_pc = flush_pc;
                m_st = 1;
            end else if (adv) begin
                if (br_valid)       m_pc = br_target;
                else if (m_st == 2) m_pc = m_pend;
                else                m_pc = m_pc + 32'd4;
                m_st = 1;
            end else if (br_valid) begin
                m_pend = br_target;
                m_st   = 2;
            end
            m_mis = |m_pc[1:0];
        end
        e.pc   = m_pc;
        e.vld  = (m_st != 0);
        e.mis  = m_mis;
        e.pend = (m_st == 2);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("pc",       64'(pc),               64'(e.pc));
            check("pc_valid", 64'(pc_valid),         64'(e.vld));
            check("misalign", 64'(pc_misalign),      64'(e.mis));
            check("pending",  64'(redirect_pending), 64'(e.pend));
        end
    endtask

    task automatic idle_inputs();
        stall     = '0;
        flush     = 1'b0;
        br_valid  = 1'b0;
    endtask

    task automatic cycle16();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; flush_pc = '0;
        br_valid = 1'b0; br_target = '0; fetch_ready = 1'b1;
        b_rst = 1'b1; b_stall = '0; b_flush = 1'b0; b_flush_pc = '0;
        b_br_valid = 1'b0; b_br_target = '0; b_fetch_ready = 1'b1;

        // Reset state, then boot: RESET_VEC fetched first, then sequential
        cycle();
        cycle();
        check("rst_pc",    64'(pc),       64'(RV));
        check("rst_valid", 64'(pc_valid), 64'd0);
        rst = 1'b0;
        cycle();
        check("boot_pc",    64'(pc),       64'h0000_0000_BFC0_0000);
        check("boot_valid", 64'(pc_valid), 64'd1);
        cycle();
        check("seq_4", 64'(pc), 64'h0000_0000_BFC0_0004);
        cycle();
        check("seq_8", 64'(pc), 64'h0000_0000_BFC0_0008);

        // Unstalled branch
        br_valid = 1'b1; br_target = 32'h0000_0100;
        cycle();
        check("br_direct", 64'(pc), 64'h100);
        idle_inputs();

        // Branch during a 3-cycle stall is parked, then applied
        stall = 6'h01; br_valid = 1'b1; br_target = 32'h0000_0200;
        cycle();
        check("stall_hold", 64'(pc), 64'h100);
        check("stall_pend", 64'(redirect_pending), 64'd1);
        br_valid = 1'b0;
        cycle();
        cycle();
        stall = '0;
        cycle();
        check("pend_apply", 64'(pc), 64'h200);
        check("pend_clear", 64'(redirect_pending), 64'd0);
        cycle();

        // Flush with branch, stall and not-ready while pending: flush wins
        stall = 6'h01; br_valid = 1'b1; br_target = 32'h0000_0300;
        cycle();
        fetch_ready = 1'b0; flush = 1'b1; flush_pc = 32'hBFC0_0380;
        cycle();
        check("flush_pc",   64'(pc), 64'h0000_0000_BFC0_0380);
        check("flush_pend", 64'(redirect_pending), 64'd0);
        idle_inputs(); fetch_ready = 1'b1;
        cycle();
        check("flush_drop", 64'(pc), 64'h0000_0000_BFC0_0384);

        // Newest parked branch wins; branch on releasing cycle beats parked one
        stall = 6'h01; br_valid = 1'b1; br_target = 32'h0000_0400;
        cycle();
        br_target = 32'h0000_0500;
        cycle();
        br_valid = 1'b0; stall = '0;
        cycle();
        check("pend_newest", 64'(pc), 64'h500);
        stall = 6'h01; br_valid = 1'b1; br_target = 32'h0000_0600;
        cycle();
        stall = '0; br_target = 32'h0000_0700;
        cycle();
        check("pend_bypass", 64'(pc), 64'h700);
        idle_inputs();

        // Higher stall bits do not hold the PC
        stall = 6'h3E;
        cycle();
        check("stall_hi", 64'(pc), 64'h704);
        idle_inputs();

        // Wrap-around and misaligned target
        br_valid = 1'b1; br_target = 32'hFFFF_FFFC;
        cycle();
        br_valid = 1'b0;
        cycle();
        check("wrap_pc",  64'(pc), 64'h0);
        check("wrap_mis", 64'(pc_misalign), 64'd0);
        br_valid = 1'b1; br_target = 32'h0000_0102;
        cycle();
        check("mis_pc",   64'(pc), 64'h102);
        check("mis_flag", 64'(pc_misalign), 64'd1);
        idle_inputs();
        cycle();

        // Reset in PEND mid-stall
        stall = 6'h01; br_valid = 1'b1; br_target = 32'h0000_0800;
        cycle();
        br_valid = 1'b0; rst = 1'b1;
        cycle();
        check("rstp_pc",   64'(pc), 64'(RV));
        check("rstp_vld",  64'(pc_valid), 64'd0);
        check("rstp_pend", 64'(redirect_pending), 64'd0);
        rst = 1'b0; idle_inputs();
        cycle();

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            rst         = ($urandom_range(0, 39) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            flush_pc    = $urandom;
            br_valid    = ($urandom_range(0, 3) == 0);
            br_target   = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            stall       = 6'($urandom);
            stall[0]    = ($urandom_range(0, 2) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst = 1'b0; idle_inputs(); fetch_ready = 1'b1;

        // 16-bit instance: STEP=2, single alignment bit
        cycle16();
        check("b_rst_pc",  64'(b_pc), 64'h0010);
        check("b_rst_vld", 64'(b_pc_valid), 64'd0);
        b_rst = 1'b0;
        cycle16();
        check("b_boot_pc",  64'(b_pc), 64'h0010);
        check("b_boot_vld", 64'(b_pc_valid), 64'd1);
        cycle16();
        check("b_seq", 64'(b_pc), 64'h0012);
        b_br_valid = 1'b1; b_br_target = 16'h0100;
        cycle16();
        check("b_br", 64'(b_pc), 64'h0100);
        b_br_valid = 1'b0;
        cycle16();
        check("b_seq2", 64'(b_pc), 64'h0102);
        check("b_mis0", 64'(b_pc_misalign), 64'd0);
        b_br_valid = 1'b1; b_br_target = 16'h0101;
        cycle16();
        check("b_mis1", 64'(b_pc_misalign), 64'd1);
        b_br_valid = 1'b0;
        b_br_target = 16'hFFFE;
        b_br_valid = 1'b1;
        cycle16();
        b_br_valid = 1'b0;
        cycle16();
        check("b_wrap", 64'(b_pc), 64'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
